// File: rtl/bus_transfer_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bus_transfer_scheduler
// Description : Turns queued register-to-register move commands into the
//               select_source / select_destination codes for the shared
//               16-bit bus. Each command issues its source in one cycle and
//               its destination in the next. Back-to-back commands overlap,
//               so one transfer completes per cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   clock              : system clock; all state updates on the rising edge
//   reset              : synchronous, active-high; clears queue and stages
//   cmd_valid          : a command is offered on cmd_src / cmd_dst
//   cmd_ready          : the queue can accept a command (not full)
//   cmd_src            : 4-bit bus source code of the offered command
//   cmd_dst            : 3-bit bus destination code of the offered command
//   stall              : holds off new source issues (destinations still drain)
//   select_source      : registered source code to the bus (0000 = none)
//   select_destination : registered destination code to the bus (000 = none)
//   xfer_done          : high in the cycle a destination is written
//   cmd_error          : one-cycle pulse after an illegal command is rejected
//   busy               : queue non-empty or a transfer in either stage
//   fifo_level         : current queue occupancy
//   xfer_count         : completed transfers, wraps modulo 2^CNT_W
//------------------------------------------------------------------------------
module bus_transfer_scheduler #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [3:0]                 cmd_src,
   input  logic [2:0]                 cmd_dst,
   input  logic                       stall,
   output logic [3:0]                 select_source,
   output logic [2:0]                 select_destination,
   output logic                       xfer_done,
   output logic                       cmd_error,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [CNT_W-1:0]           xfer_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   // Queue storage: {src, dst} per entry.
   logic [6:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level;

   logic             full;
   logic             empty;
   logic             src_ok;
   logic             dst_ok;
   logic             accept;
   logic             push;
   logic             pop;

   // Pipeline stages: S holds the destination of the transfer whose source
   // is on the bus now; D marks the transfer whose destination is on the bus.
   logic             s_valid;
   logic [2:0]       s_dst;
   logic             d_valid;

   assign full      = (level == LVL_W'(DEPTH));
   assign empty     = (level == '0);
   assign cmd_ready = ~full;

   always_comb begin
      src_ok = 1'b0;
      case (cmd_src)
         4'b0001, 4'b0010, 4'b0011,
         4'b0101, 4'b0110, 4'b0111,
         4'b1000, 4'b1001, 4'b1010, 4'b1011: src_ok = 1'b1;
         default:                            src_ok = 1'b0;
      endcase
   end

   always_comb begin
      dst_ok = 1'b0;
      case (cmd_dst)
         3'b010, 3'b011, 3'b110: dst_ok = 1'b1;
         default:                dst_ok = 1'b0;
      endcase
   end

   // cmd_ready is derived from the level alone, so a full queue refuses a
   // push even in a cycle where the head is being popped.
   assign accept = cmd_valid & cmd_ready;
   assign push   = accept & src_ok & dst_ok;
   assign pop    = ~stall & ~empty;

   // Command queue
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= {cmd_src, cmd_dst};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Source-issue and destination stages
   always_ff @(posedge clock) begin
      if (reset) begin
         s_valid            <= 1'b0;
         s_dst              <= '0;
         select_source      <= '0;
         d_valid            <= 1'b0;
         select_destination <= '0;
         cmd_error          <= 1'b0;
         xfer_count         <= '0;
      end else begin
         s_valid       <= pop;
         s_dst         <= pop ? mem[rd_ptr][2:0] : 3'b000;
         select_source <= pop ? mem[rd_ptr][6:3] : 4'b0000;

         // D always follows S; stall only gates new sources.
         d_valid            <= s_valid;
         select_destination <= s_valid ? s_dst : 3'b000;

         cmd_error <= accept & ~(src_ok & dst_ok);

         if (d_valid) begin
            xfer_count <= xfer_count + CNT_W'(1);
         end
      end
   end

   assign xfer_done  = d_valid;
   assign fifo_level = level;
   assign busy       = ~empty | s_valid | d_valid;

endmodule
`default_nettype wire

// File: tb/tb_bus_transfer_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_bus_transfer_scheduler
// Description : Directed self-checking bench for bus_transfer_scheduler.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bus_transfer_scheduler;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic             clock;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_src;
   logic [2:0]       cmd_dst;
   logic             stall;
   logic [3:0]       select_source;
   logic [2:0]       select_destination;
   logic             xfer_done;
   logic             cmd_error;
   logic             busy;
   logic [2:0]       fifo_level;
   logic [CNT_W-1:0] xfer_count;

   int total;
   int passed;

   bus_transfer_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock              (clock),
      .reset              (reset),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_src            (cmd_src),
      .cmd_dst            (cmd_dst),
      .stall              (stall),
      .select_source      (select_source),
      .select_destination (select_destination),
      .xfer_done          (xfer_done),
      .cmd_error          (cmd_error),
      .busy               (busy),
      .fifo_level         (fifo_level),
      .xfer_count         (xfer_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks source, destination and done in one call.
   task automatic bus(input string tag, input logic [3:0] s, input logic [2:0] d, input logic x);
      chk({tag, ".src"},  32'(select_source),      32'(s));
      chk({tag, ".dst"},  32'(select_destination), 32'(d));
      chk({tag, ".done"}, 32'(xfer_done),          32'(x));
   endtask

   task automatic drive(input logic v, input logic [3:0] s, input logic [2:0] d);
      cmd_valid = v;
      cmd_src   = s;
      cmd_dst   = d;
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   initial begin
      total  = 0;
      passed = 0;
      reset  = 1'b1;
      stall  = 1'b0;
      drive(1'b0, 4'h0, 3'h0);

      // ---------------- reset state
      cyc(); cyc();
      bus("rst", 4'h0, 3'h0, 1'b0);
      chk("rst.err",   32'(cmd_error),  0);
      chk("rst.cnt",   32'(xfer_count), 0);
      chk("rst.lvl",   32'(fifo_level), 0);
      chk("rst.busy",  32'(busy),       0);
      chk("rst.ready", 32'(cmd_ready),  1);
      reset = 1'b0;
      cyc();

      // ---------------- single command
      drive(1'b1, 4'b0001, 3'b010);
      cyc(); drive(1'b0, 4'h0, 3'h0);
      chk("one.lvl",  32'(fifo_level), 1);
      chk("one.busy", 32'(busy),       1);
      bus("one.c0", 4'h0, 3'h0, 1'b0);
      cyc(); bus("one.c1", 4'b0001, 3'h0, 1'b0);
      chk("one.lvl0", 32'(fifo_level), 0);
      cyc(); bus("one.c2", 4'h0, 3'b010, 1'b1);
      cyc(); bus("one.c3", 4'h0, 3'h0, 1'b0);
      chk("one.cnt",   32'(xfer_count), 1);
      chk("one.idle",  32'(busy),       0);

      // ---------------- back-to-back
      drive(1'b1, 4'b0010, 3'b011);
      cyc(); drive(1'b1, 4'b0101, 3'b110);
      cyc(); bus("b2b.c1", 4'b0010, 3'h0, 1'b0);
      drive(1'b1, 4'b1011, 3'b010);
      cyc(); drive(1'b0, 4'h0, 3'h0);
      bus("b2b.c2", 4'b0101, 3'b011, 1'b1);
      cyc(); bus("b2b.c3", 4'b1011, 3'b110, 1'b1);
      cyc(); bus("b2b.c4", 4'h0, 3'b010, 1'b1);
      chk("b2b.busy1", 32'(busy), 1);
      cyc(); bus("b2b.c5", 4'h0, 3'h0, 1'b0);
      chk("b2b.busy0", 32'(busy),       0);
      chk("b2b.cnt",   32'(xfer_count), 4);

      // ---------------- fill under stall, then drain
      stall = 1'b1;
      drive(1'b1, 4'b0001, 3'b010); cyc(); chk("fill.l1", 32'(fifo_level), 1);
      drive(1'b1, 4'b0010, 3'b011); cyc(); chk("fill.l2", 32'(fifo_level), 2);
      drive(1'b1, 4'b0011, 3'b110); cyc(); chk("fill.l3", 32'(fifo_level), 3);
      chk("fill.rdy3", 32'(cmd_ready), 1);
      drive(1'b1, 4'b0101, 3'b010); cyc(); chk("fill.l4", 32'(fifo_level), 4);
      chk("fill.rdy4", 32'(cmd_ready), 0);
      drive(1'b1, 4'b0110, 3'b011); cyc();
      chk("fill.l4b",  32'(fifo_level), 4);
      chk("fill.stl",  32'(select_source), 0);
      stall = 1'b0;
      cyc(); chk("drn.s1", 32'(select_source), 4'b0001);
      chk("drn.l1",  32'(fifo_level), 3);
      chk("drn.rdy", 32'(cmd_ready),  1);
      cyc(); drive(1'b0, 4'h0, 3'h0);
      bus("drn.c2", 4'b0010, 3'b010, 1'b1);
      chk("drn.l2", 32'(fifo_level), 3);
      cyc(); bus("drn.c3", 4'b0011, 3'b011, 1'b1); chk("drn.l3", 32'(fifo_level), 2);
      cyc(); bus("drn.c4", 4'b0101, 3'b110, 1'b1); chk("drn.l4", 32'(fifo_level), 1);
      cyc(); bus("drn.c5", 4'b0110, 3'b010, 1'b1); chk("drn.l5", 32'(fifo_level), 0);
      cyc(); bus("drn.c6", 4'h0, 3'b011, 1'b1);
      cyc(); bus("drn.c7", 4'h0, 3'h0, 1'b0);
      chk("drn.cnt",  32'(xfer_count), 9);
      chk("drn.busy", 32'(busy),       0);

      // ---------------- illegal commands
      drive(1'b1, 4'b0100, 3'b010);
      cyc(); drive(1'b0, 4'h0, 3'h0);
      chk("ill.err1",  32'(cmd_error),  1);
      chk("ill.lvl1",  32'(fifo_level), 0);
      cyc(); chk("ill.gap", 32'(cmd_error), 0);
      drive(1'b1, 4'b0001, 3'b001);
      cyc(); drive(1'b0, 4'h0, 3'h0);
      chk("ill.err2",  32'(cmd_error),  1);
      chk("ill.lvl2",  32'(fifo_level), 0);
      cyc(); chk("ill.end", 32'(cmd_error), 0);
      bus("ill.bus", 4'h0, 3'h0, 1'b0);
      chk("ill.busy", 32'(busy), 0);

      // ---------------- stall right after a source issue
      drive(1'b1, 4'b0111, 3'b011);
      cyc(); drive(1'b1, 4'b1000, 3'b110);
      cyc(); drive(1'b0, 4'h0, 3'h0);
      bus("stl.c1", 4'b0111, 3'h0, 1'b0);
      stall = 1'b1;
      cyc(); bus("stl.c2", 4'h0, 3'b011, 1'b1);
      chk("stl.lvl", 32'(fifo_level), 1);
      cyc(); bus("stl.c3", 4'h0, 3'h0, 1'b0);
      chk("stl.busy", 32'(busy), 1);
      stall = 1'b0;
      cyc(); bus("stl.c4", 4'b1000, 3'h0, 1'b0);
      cyc(); bus("stl.c5", 4'h0, 3'b110, 1'b1);
      cyc(); chk("stl.cnt", 32'(xfer_count), 11);

      // ---------------- reset with work queued and in flight
      stall = 1'b1;
      drive(1'b1, 4'b1001, 3'b010); cyc();
      drive(1'b1, 4'b1010, 3'b011); cyc();
      drive(1'b1, 4'b0001, 3'b110); cyc();
      drive(1'b1, 4'b0010, 3'b010); cyc();
      drive(1'b0, 4'h0, 3'h0);
      stall = 1'b0;
      cyc(); chk("mid.src", 32'(select_source), 4'b1001);
      chk("mid.lvl", 32'(fifo_level), 3);
      reset = 1'b1;
      stall = 1'b1;
      cyc(); reset = 1'b0; stall = 1'b0;
      bus("mid.rst", 4'h0, 3'h0, 1'b0);
      chk("mid.busy", 32'(busy),       0);
      chk("mid.lvl0", 32'(fifo_level), 0);
      chk("mid.cnt",  32'(xfer_count), 0);
      cyc(); bus("mid.after1", 4'h0, 3'h0, 1'b0);
      cyc(); bus("mid.after2", 4'h0, 3'h0, 1'b0);
      chk("mid.cnt2", 32'(xfer_count), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bus_transfer_scheduler.md
Name: bus_transfer_scheduler

Overview:
Sequences register-to-register moves over the processor's shared 16-bit bus by generating its select_source and select_destination codes. A queued command's source selection is issued in one cycle and its destination selection in the next. Consecutive commands are pipelined, so the destination of transfer N and the source of transfer N+1 share a cycle. Sits between the control unit (command producer) and the bus.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2
CNT_W, 8, width of completed-transfer counter

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_src  input  4  bus source code
cmd_dst  input  3  bus destination code
stall  input  1  inhibit issue of new source selections
select_source  output  4  source code to bus, registered
select_destination  output  3  destination code to bus, registered
xfer_done  output  1  one-cycle pulse: a transfer's destination is being written this cycle
cmd_error  output  1  one-cycle pulse: illegal command rejected
busy  output  1  FIFO non-empty or any pipeline stage valid
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
xfer_count  output  CNT_W  completed transfers, wraps modulo 2^CNT_W

Behaviour:
- Reset clears all of the following: FIFO, pointers, both stages, select_source=0000, select_destination=000, xfer_done=0, cmd_error=0, xfer_count=0, fifo_level=0.
- Reset mid-transfer discards queued and in-flight commands; no xfer_done is produced for them.
- Legal sources are 0001, 0010, 0011, 0101, 0110, 0111, 1000, 1001, 1010 and 1011.
- Legal destinations are 010, 011 and 110.
- Handshake: cmd_ready = !full, computed combinationally from the level. A command is accepted when cmd_valid && cmd_ready at a rising edge.
- A legal accepted command is enqueued.
- An accepted command with an illegal src or dst is not enqueued. cmd_error pulses high in the next cycle.
- No same-cycle bypass. A full FIFO does not accept a push even when a pop occurs in the same cycle.
- Stage S (source issue): at each edge, if stall=0 and the FIFO is non-empty, pop the head. Next cycle select_source = head.src and the head's dst is held in S. Otherwise select_source=0000 and S is invalid.
- Stage D (destination): at each edge, D takes S's contents. If D is valid, select_destination = dst and xfer_done=1. Otherwise select_destination=000 and xfer_done=0.
- Stage D always drains, regardless of stall. The bus holds its value while the source code is 0000.
- Latency: a command accepted at edge t into an empty, idle scheduler gives select_source at cycle t+1 → t+2. select_destination and xfer_done follow one cycle later. Sustained throughput is one transfer per cycle.
- xfer_count increments at each edge where xfer_done=1 and wraps from 2^CNT_W-1 to 0.
- fifo_level: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- busy is combinational: (fifo_level != 0) | S.valid | D.valid.

Test Plan:
- Reset, then one command src=0001, dst=010 → select_source=0001 for exactly one cycle, then select_destination=010 with xfer_done=1 for one cycle, then 0000/000 idle; xfer_count=1.
- Back-to-back commands (0010,011), (0101,110), (1011,010) → source codes on consecutive cycles; each destination appears one cycle after its source; three xfer_done pulses; busy falls after the last one.
- Five pushes with stall=1 and DEPTH=4 → cmd_ready=0 after the 4th push and fifo_level=4. Release stall → four transfers issue in order, cmd_ready returns to 1, and the 5th command is accepted once ready is high.
- Illegal commands src=0100 and dst=001 → cmd_error pulses once for each; fifo_level unchanged; no bus activity.
- Stall asserted the cycle after a source issue → the pending destination still completes; no new source code appears while stall=1.
- Reset asserted with 3 commands queued and 1 in flight → the next cycle shows 0000/000, busy=0, fifo_level=0, no xfer_done, xfer_count=0.
